// File: rtl/pm_serial_loader.sv
// Serial program-memory loader: 8N1 UART receiver feeding a packet FSM
// (SYNC, COUNT, data..., CHECKSUM) that writes the MPU341 program memory
// and holds the core in reset until a complete, checksum-clean image lands.
module pm_serial_loader #(
  parameter int       CLKS_PER_BIT = 16,
  parameter bit [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       pm_wr_en,
  output logic [7:0] pm_wr_addr,
  output logic [7:0] pm_wr_data,
  output logic       mpu_hold,
  output logic       load_done,
  output logic       load_error
);

  localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_ERR} pstate_t;

  logic          rx_s1, rx_s2, rx_d;
  ustate_t       ustate;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_valid, frame_err;
  logic [7:0]    rx_byte;

  pstate_t       state;
  logic [8:0]    remaining;
  logic [7:0]    addr, sum;

  // Two-flop synchronizer plus one delay flop for falling-edge detection;
  // all idle high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // UART receiver: mid-bit sampling timed from the start-bit falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ustate     <= U_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_byte    <= '0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (ustate)
        U_IDLE: begin
          cnt <= '0;
          if (rx_d && !rx_s2) ustate <= U_START;
        end
        U_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            // Line back high at mid start bit: a glitch, not a frame.
            ustate  <= rx_s2 ? U_IDLE : U_DATA;
          end else cnt <= cnt + 1'b1;
        end
        U_DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            shreg <= {rx_s2, shreg[7:1]};
            if (bit_idx == 3'd7) ustate <= U_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        U_STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt    <= '0;
            ustate <= U_IDLE;
            if (rx_s2) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else frame_err <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: ustate <= U_IDLE;
      endcase
    end
  end

  // Packet FSM: frames bytes into a load, drives the write port and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      remaining  <= '0;
      addr       <= '0;
      sum        <= '0;
      pm_wr_en   <= 1'b0;
      pm_wr_addr <= '0;
      pm_wr_data <= '0;
      mpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      pm_wr_en <= 1'b0;
      if (byte_valid) begin
        case (state)
          S_IDLE, S_ERR: begin
            if (rx_byte == SYNC_BYTE) begin
              state      <= S_LEN;
              mpu_hold   <= 1'b1;
              load_done  <= 1'b0;
              load_error <= 1'b0;
            end
          end
          S_LEN: begin
            remaining <= (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
            addr      <= '0;
            sum       <= '0;
            state     <= S_DATA;
          end
          S_DATA: begin
            pm_wr_en   <= 1'b1;
            pm_wr_addr <= addr;
            pm_wr_data <= rx_byte;
            addr       <= addr + 8'd1;
            sum        <= sum + rx_byte;
            remaining  <= remaining - 9'd1;
            if (remaining == 9'd1) state <= S_CHK;
          end
          S_CHK: begin
            if (rx_byte == sum) begin
              state     <= S_IDLE;
              load_done <= 1'b1;
              mpu_hold  <= 1'b0;
            end else begin
              state      <= S_ERR;
              load_error <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (frame_err && (state == S_LEN || state == S_DATA || state == S_CHK)) begin
        // Keep the core held: a partial image must never run.
        state      <= S_ERR;
        load_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pm_serial_loader.sv
// Bench for pm_serial_loader: table vectors, hand sequences for latency,
// glitch, full 256-byte load and mid-packet reset, then random packets
// checked against a stream-level packet model.
module tb_pm_serial_loader;

  localparam int CPB = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0, reset = 1'b1, rx = 1'b1;
  logic pm_wr_en, mpu_hold, load_done, load_error;
  logic [7:0] pm_wr_addr, pm_wr_data;

  pm_serial_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .pm_wr_en(pm_wr_en), .pm_wr_addr(pm_wr_addr), .pm_wr_data(pm_wr_data),
    .mpu_hold(mpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [15:0] got_q[$], exp_q[$];
  int wr_cyc_q[$];
  int hold_fall_cyc = -1, done_rise_cyc = -1;
  logic prev_hold = 1'b0, prev_done = 1'b0;
  bit m_done = 0, m_err = 0, m_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the write port and status edges away from the active edge.
  always @(negedge clk) begin
    if (pm_wr_en) begin
      got_q.push_back({pm_wr_addr, pm_wr_data});
      wr_cyc_q.push_back(cyc);
    end
    if (prev_hold && !mpu_hold) hold_fall_cyc = cyc;
    if (!prev_done && load_done) done_rise_cyc = cyc;
    prev_hold = mpu_hold;
    prev_done = load_done;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int bad);
    for (int i = 0; i < s.size(); i++) send_byte(s[i], i != bad);
  endtask

  // Stream-level model: hunt for a good SYNC, then read one packet by its
  // length field and judge the checksum. Index 'bad' is a byte whose stop
  // bit is 0 (lost byte, framing error).
  task automatic model(input logic [7:0] s[$], input int bad);
    int i = 0, n;
    logic [7:0] sum = 8'h00;
    while (i < s.size() && !(s[i] == SYNC && i != bad)) i++;
    if (i >= s.size()) return;
    m_done = 0; m_err = 0; m_hold = 1;
    i++;
    if (i >= s.size()) return;
    if (i == bad) begin m_err = 1; return; end
    n = (s[i] == 8'h00) ? 256 : int'(s[i]);
    i++;
    for (int k = 0; k < n; k++) begin
      if (i >= s.size()) return;
      if (i == bad) begin m_err = 1; return; end
      exp_q.push_back({k[7:0], s[i]});
      sum = sum + s[i];
      i++;
    end
    if (i >= s.size()) return;
    if (i == bad) begin m_err = 1; return; end
    if (s[i] == sum) begin m_done = 1; m_hold = 0; end
    else m_err = 1;
  endtask

  task automatic cmp_writes(input string name);
    check({name, " nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s wr%0d", name, i), got_q[i], exp_q[i]);
  endtask

  task automatic cmp_flags(input string name, input bit d, input bit e, input bit h);
    check({name, " load_done"}, load_done, d);
    check({name, " load_error"}, load_error, e);
    check({name, " mpu_hold"}, mpu_hold, h);
  endtask

  task automatic run(input string name, input logic [7:0] s[$], input int bad);
    got_q.delete(); exp_q.delete(); wr_cyc_q.delete();
    model(s, bad);
    send_stream(s, bad);
    repeat (20) @(negedge clk);
    cmp_writes(name);
  endtask

  typedef struct {
    logic [7:0] b[8];
    int n, bad, wr;
    bit done, err, hold;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [7:0] s[$];
    vt[0] = '{'{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h66,8'h0,8'h0}, 6, -1, 3, 1, 0, 0};
    vt[1] = '{'{8'hA5,8'h02,8'h10,8'h20,8'h31,8'h0,8'h0,8'h0}, 5, -1, 2, 0, 1, 1};
    vt[2] = '{'{8'hA5,8'h01,8'h7F,8'h7F,8'h0,8'h0,8'h0,8'h0}, 4, -1, 1, 1, 0, 0};
    vt[3] = '{'{8'h00,8'hFF,8'h0,8'h0,8'h0,8'h0,8'h0,8'h0}, 2, -1, 0, 1, 0, 0};
    vt[4] = '{'{8'hA5,8'h03,8'hAA,8'h55,8'h0,8'h0,8'h0,8'h0}, 4, 3, 1, 0, 1, 1};
    vt[5] = '{'{8'h11,8'h22,8'h0,8'h0,8'h0,8'h0,8'h0,8'h0}, 2, -1, 0, 0, 1, 1};
    vt[6] = '{'{8'hA5,8'h01,8'hA5,8'hA5,8'h0,8'h0,8'h0,8'h0}, 4, -1, 1, 1, 0, 0};
    vt[7] = '{'{8'hA5,8'h02,8'hFF,8'h02,8'h01,8'h0,8'h0,8'h0}, 5, -1, 2, 1, 0, 0};
    vt[8] = '{'{8'h5A,8'hA5,8'h01,8'h00,8'h00,8'h0,8'h0,8'h0}, 5, 0, 1, 1, 0, 0};

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst pm_wr_en", pm_wr_en, 0);
    check("rst pm_wr_addr", pm_wr_addr, 0);
    check("rst pm_wr_data", pm_wr_data, 0);
    cmp_flags("rst", 0, 0, 0);

    // Table vectors, run back to back so status carries between them.
    for (int v = 0; v < 9; v++) begin
      s.delete();
      for (int k = 0; k < vt[v].n; k++) s.push_back(vt[v].b[k]);
      run($sformatf("vec%0d", v), s, vt[v].bad);
      check($sformatf("vec%0d wrcount", v), got_q.size(), vt[v].wr);
      cmp_flags($sformatf("vec%0d", v), vt[v].done, vt[v].err, vt[v].hold);
    end

    // Glitch in idle: no byte, no status change, receiver still usable.
    rx = 1'b0;
    repeat (4) @(posedge clk);
    rx = 1'b1;
    got_q.delete();
    repeat (40) @(negedge clk);
    check("glitch nwrites", got_q.size(), 0);
    cmp_flags("glitch", 1, 0, 0);

    // Latency: writes 1 frame apart, hold falls with done one frame after
    // the last write (both 1 cycle after their byte_valid).
    hold_fall_cyc = -1; done_rise_cyc = -1;
    s = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
    run("lat", s, -1);
    cmp_flags("lat", 1, 0, 0);
    if (wr_cyc_q.size() == 3) begin
      check("lat wr spacing", wr_cyc_q[1] - wr_cyc_q[0], 11 * CPB);
      check("lat hold vs last wr", hold_fall_cyc - wr_cyc_q[2], 11 * CPB);
      check("lat done vs hold", done_rise_cyc, hold_fall_cyc);
    end else check("lat wr count", wr_cyc_q.size(), 3);

    // Full 256-byte image, COUNT = 0.
    s = '{8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) s.push_back(i[7:0]);
    s.push_back(8'h80);
    run("full", s, -1);
    check("full last addr", (got_q.size() > 0) ? int'(got_q[got_q.size()-1][15:8]) : -1, 8'hFF);
    cmp_flags("full", 1, 0, 0);

    // Reset after the second data byte of a 4-byte packet.
    s = '{8'hA5, 8'h04, 8'h11, 8'h22};
    run("pre_rst", s, -1);
    check("pre_rst hold", mpu_hold, 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midrst pm_wr_en", pm_wr_en, 0);
    check("midrst pm_wr_addr", pm_wr_addr, 0);
    check("midrst pm_wr_data", pm_wr_data, 0);
    cmp_flags("midrst", 0, 0, 0);
    m_done = 0; m_err = 0; m_hold = 0;
    s = '{8'h33, 8'h44, 8'hAA};
    run("post_rst", s, -1);
    cmp_flags("post_rst", 0, 0, 0);

    // Random packets: junk, then a packet that may carry a bad checksum
    // or be cut short by a framing error.
    for (int p = 0; p < 6; p++) begin
      int n, bad, base;
      logic [7:0] b, sum;
      s.delete();
      repeat ($urandom_range(0, 2)) begin
        b = $urandom_range(0, 255);
        s.push_back((b == SYNC) ? 8'h5A : b);
      end
      base = s.size();
      n = $urandom_range(1, 8);
      sum = 8'h00;
      s.push_back(SYNC);
      s.push_back(n[7:0]);
      for (int k = 0; k < n; k++) begin
        b = $urandom_range(0, 255);
        s.push_back(b);
        sum = sum + b;
      end
      s.push_back(($urandom_range(0, 9) < 7) ? sum : sum + 8'h01);
      bad = -1;
      if ($urandom_range(0, 3) == 0) begin
        bad = base + $urandom_range(1, n + 2);
        while (s.size() > bad + 1) void'(s.pop_back());
      end
      run($sformatf("rnd%0d", p), s, bad);
      cmp_flags($sformatf("rnd%0d", p), m_done, m_err, m_hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pm_serial_loader.md
Name: pm_serial_loader

Overview:
Serial program-memory writer for the MPU341. It receives an 8N1 UART byte stream on one pin, frames it into a load packet, and writes instruction bytes into the 256x8 program memory through its write port. It holds the MPU in reset via mpu_hold while a load is in progress, then releases the core to run from address 0x00.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 4 (16 in simulation, board value set at top level).
SYNC_BYTE, 8'hA5, packet start marker.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
rx  input  1  asynchronous UART line; idles high.
pm_wr_en  output  1  one-cycle program memory write strobe.
pm_wr_addr  output  8  program memory write address.
pm_wr_data  output  8  instruction byte to write.
mpu_hold  output  1  high holds the MPU in reset; ORed into the top-level reset.
load_done  output  1  level; the last packet loaded with a good checksum.
load_error  output  1  level; the last packet failed (checksum or framing).

Behaviour:
- Reset is synchronous and active-high: reset on a clk edge. All outputs go to 0, the FSM goes to IDLE, the UART goes to idle, and the synchronizer flops are set to 1. A reset mid-packet abandons the packet. No further writes occur until a new SYNC_BYTE arrives.
- rx passes through a 2-flop synchronizer, reset to 1.
- UART receive path:
  - A falling edge on the synchronized rx starts a bit timer.
  - At CLKS_PER_BIT/2 the line is re-sampled. If it is high, the event is a glitch: no byte is produced and the receiver returns to idle.
  - Otherwise 8 data bits are sampled LSB first, one every CLKS_PER_BIT, each at mid-bit. The stop bit is sampled the same way.
  - Stop bit = 1: byte_valid pulses for 1 cycle with the byte.
  - Stop bit = 0: frame_err pulses for 1 cycle and no byte is produced.
  - The receiver re-arms immediately after sampling the stop bit.
- Packet format: SYNC_BYTE, COUNT, COUNT data bytes, CHECKSUM.
  - COUNT 0x00 means 256 bytes.
  - CHECKSUM is the sum of the data bytes mod 256.
- FSM states and transitions:
  - IDLE: a byte equal to SYNC_BYTE goes to LEN, sets mpu_hold=1, and clears load_done and load_error. Other bytes and frame_err are ignored.
  - LEN: latches remaining = (COUNT==0 ? 256 : COUNT) as a 9-bit value, clears addr to 0x00 and sum to 0, then goes to DATA.
  - DATA: on each byte, pm_wr_en=1, pm_wr_data=byte and pm_wr_addr=addr in the cycle after byte_valid, for exactly 1 cycle. Then addr increments (8-bit wrap), sum += byte (8-bit wrap) and remaining decrements. When remaining reaches 0, go to CHK.
  - CHK: byte == sum goes to IDLE with load_done=1 and mpu_hold=0. Byte != sum goes to ERR.
  - ERR: load_error=1 and mpu_hold stays 1, so the MPU never runs from a partial image. A SYNC_BYTE re-enters LEN with the flags cleared, as in IDLE. Other bytes are ignored.
- frame_err in LEN, DATA or CHK goes to ERR. Bytes already written stay written.
- A SYNC_BYTE value inside LEN, DATA or CHK is treated as ordinary data, not a restart.
- byte_valid and frame_err never occur in the same cycle. At most one write happens per received byte.
- Latency: pm_wr_en rises 1 cycle after byte_valid. load_done and the mpu_hold fall 1 cycle after the checksum byte_valid.
- pm_wr_addr and pm_wr_data hold their last values when pm_wr_en=0.

Test Plan:
- CLKS_PER_BIT=16. Send A5,03,11,22,33,66 -> writes (00,11),(01,22),(02,33), each with a 1-cycle pm_wr_en; load_done=1; mpu_hold 1→0 one cycle after the checksum byte; load_error=0.
- Send A5,02,10,20,31 (wrong checksum, correct is 30) -> 2 writes, load_error=1, mpu_hold stays 1. Then a valid A5,01,7F,7F -> load_error=0, load_done=1, mpu_hold=0.
- Send A5,00 followed by 256 bytes of value i, then checksum 0x80 -> 256 writes at addresses 00..FF with data = addr; the last address is FF; load_done=1.
- Send A5,03,AA, then a byte with stop bit 0 -> exactly 1 write (00,AA), load_error=1, mpu_hold=1. Later bytes without a SYNC_BYTE produce no writes.
- Pull rx low for 4 clks in IDLE -> no byte_valid and no state change. Bytes 00,FF before A5 -> ignored, no writes.
- Assert reset for 1 cycle after the 2nd data byte of a 4-byte packet -> all outputs 0 on the next cycle; the remaining bytes produce no writes; load_done=0 and load_error=0.
